// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single memory port between the instruction-fetch requester and
//   the data-access requester. Each access is a req/ack handshake. A counter
//   bounds the wait for mem_ack. Stall outputs freeze the pipeline registers
//   that feed a requester until its access completes.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   i_req/i_addr            fetch request and address (held until i_done)
//   i_rdata/i_done          fetched word and one-cycle completion pulse
//   d_req/d_we/d_type       data request, store flag and size/sign code
//   d_addr/d_wdata          data address and store data (held until d_done)
//   d_rdata/d_done          load data and one-cycle completion pulse
//   bus_err                 pulses with the done of a timed-out access
//   mem_req/mem_we/mem_type registered memory request, write enable, size
//   mem_addr/mem_wdata      registered memory address and write data
//   mem_ack/mem_rdata       memory completion and read data (used in BUSY only)
//   stall_if/stall_mem      combinational stalls for PC/IF_ID and EX_MEM/MEM_WB
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MTYPE_W = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [DATA_W-1:0]  i_rdata,
    output logic               i_done,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [MTYPE_W-1:0] d_type,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               d_done,
    output logic               bus_err,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MTYPE_W-1:0] mem_type,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               stall_if,
    output logic               stall_mem
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Owner / last_grant encoding: 0 = instruction fetch, 1 = data access.
    localparam logic OWN_INSTR = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    // Counter only ever reaches TIMEOUT-1.
    localparam int                 CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [MTYPE_W-1:0] FETCH_TYPE = MTYPE_W'(3);

    logic [1:0]         state_reg, state_next;
    logic               owner_reg;
    logic               last_grant_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               bus_err_reg;
    logic               mem_req_reg;
    logic               mem_we_reg;
    logic [MTYPE_W-1:0] mem_type_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;

    logic grant_valid;
    logic grant_data;
    logic ack_hit;
    logic timeout_hit;
    logic complete;

    // Arbitration: a lone requester wins; on a tie the requester that was
    // not granted last time wins.
    always_comb begin
        grant_valid = i_req | d_req;
        if (i_req && d_req) begin
            grant_data = (last_grant_reg != OWN_DATA);
        end else begin
            grant_data = d_req;
        end
    end

    // An ack in the final allowed cycle takes precedence over the timeout.
    assign ack_hit     = (state_reg == ST_BUSY) && mem_ack;
    assign timeout_hit = (state_reg == ST_BUSY) && !mem_ack && (cnt_reg == CNT_LAST);
    assign complete    = ack_hit || timeout_hit;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (grant_valid) state_next = ST_BUSY;
            ST_BUSY: if (complete)    state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_INSTR;
            last_grant_reg <= OWN_INSTR;
            cnt_reg        <= '0;
            bus_err_reg    <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_type_reg   <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        mem_req_reg    <= 1'b1;
                        owner_reg      <= grant_data;
                        last_grant_reg <= grant_data;
                        cnt_reg        <= '0;
                        if (grant_data) begin
                            mem_we_reg    <= d_we;
                            mem_type_reg  <= d_type;
                            mem_addr_reg  <= d_addr;
                            mem_wdata_reg <= d_wdata;
                        end else begin
                            mem_we_reg    <= 1'b0;
                            mem_type_reg  <= FETCH_TYPE;
                            mem_addr_reg  <= i_addr;
                            mem_wdata_reg <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (complete) begin
                        mem_req_reg <= 1'b0;
                        bus_err_reg <= timeout_hit;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    bus_err_reg <= 1'b0;
                end
                default: begin
                    bus_err_reg <= 1'b0;
                end
            endcase
        end
    end

    // Per-requester completion pulse and read-data holding register.
    // Index 0 is the fetch side, index 1 the data side.
    logic [1:0]        done_vec;
    logic [DATA_W-1:0] rdata_vec [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic OWN = (gi == 1);

        logic              done_reg;
        logic [DATA_W-1:0] rdata_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                done_reg  <= 1'b0;
                rdata_reg <= '0;
            end else if (complete && (owner_reg == OWN)) begin
                done_reg  <= 1'b1;
                // A timed-out access returns zero data.
                rdata_reg <= ack_hit ? mem_rdata : '0;
            end else if (state_reg == ST_DONE) begin
                done_reg <= 1'b0;
            end
        end

        assign done_vec[gi]  = done_reg;
        assign rdata_vec[gi] = rdata_reg;
    end

    assign i_done    = done_vec[0];
    assign d_done    = done_vec[1];
    assign i_rdata   = rdata_vec[0];
    assign d_rdata   = rdata_vec[1];
    assign bus_err   = bus_err_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_type  = mem_type_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    // A data access blocks the whole front of the pipeline as well.
    assign stall_mem = d_req & ~d_done;
    assign stall_if  = (i_req & ~i_done) | stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [63:0] i_addr;
    logic [63:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_type;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_done;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_type;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    int total = 0;
    int bad   = 0;
    int pulses;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (64),
        .DATA_W (64),
        .MTYPE_W(3),
        .TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_done   (i_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_type   (d_type),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .bus_err  (bus_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_type (mem_type),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_type = 3'd0; d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();

        // Reset state
        check("rst_mem_req",  64'(mem_req),  64'd0);
        check("rst_i_done",   64'(i_done),   64'd0);
        check("rst_d_done",   64'(d_done),   64'd0);
        check("rst_bus_err",  64'(bus_err),  64'd0);
        check("rst_mem_addr", mem_addr,      64'd0);
        check("rst_mem_type", 64'(mem_type), 64'd0);
        check("rst_i_rdata",  i_rdata,       64'd0);
        check("rst_d_rdata",  d_rdata,       64'd0);
        reset = 1'b0;
        step();

        // ---- Single fetch, ack two cycles after mem_req rises ----
        i_req = 1'b1; i_addr = 64'h1000;
        #1 check("f1_stall_if_req", 64'(stall_if), 64'd1);
        step();
        check("f1_mem_req_c1", 64'(mem_req),  64'd1);
        check("f1_mem_we",     64'(mem_we),   64'd0);
        check("f1_mem_type",   64'(mem_type), 64'd3);
        check("f1_mem_addr",   mem_addr,      64'h1000);
        step();
        check("f1_mem_req_c2", 64'(mem_req), 64'd1);
        step();
        check("f1_mem_req_c3", 64'(mem_req), 64'd1);
        check("f1_no_done",    64'(i_done),  64'd0);
        mem_ack = 1'b1; mem_rdata = 64'h13;
        step();
        check("f1_mem_req_off", 64'(mem_req), 64'd0);
        check("f1_i_done",      64'(i_done),  64'd1);
        check("f1_i_rdata",     i_rdata,      64'h13);
        check("f1_stall_if_dn", 64'(stall_if), 64'd0);
        i_req = 1'b0; mem_ack = 1'b0;
        step();
        check("f1_i_done_clr", 64'(i_done), 64'd0);
        check("f1_i_rdata_hold", i_rdata, 64'h13);
        $display("txn fetch addr=1000 rdata=%h", i_rdata);

        // ---- Simultaneous requests after reset: data first ----
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b1; i_addr = 64'h1100;
        d_req = 1'b1; d_we = 1'b1; d_type = 3'd2; d_addr = 64'h2000; d_wdata = 64'hDEAD;
        step();
        check("tie1_mem_we",    64'(mem_we),   64'd1);
        check("tie1_mem_addr",  mem_addr,      64'h2000);
        check("tie1_mem_wdata", mem_wdata,     64'hDEAD);
        check("tie1_mem_type",  64'(mem_type), 64'd2);
        check("tie1_stall_if",  64'(stall_if), 64'd1);
        check("tie1_stall_mem", 64'(stall_mem), 64'd1);
        mem_ack = 1'b1; mem_rdata = 64'h77;
        step();
        check("tie1_d_done",   64'(d_done),   64'd1);
        check("tie1_d_rdata",  d_rdata,       64'h77);
        check("tie1_i_done",   64'(i_done),   64'd0);
        check("tie1_stall_if", 64'(stall_if), 64'd1);
        check("tie1_stall_mem_dn", 64'(stall_mem), 64'd0);
        mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        check("tie2_wait_req", 64'(mem_req),  64'd0);
        check("tie2_stall_if", 64'(stall_if), 64'd1);
        step();
        check("tie2_mem_req",  64'(mem_req),  64'd1);
        check("tie2_mem_addr", mem_addr,      64'h1100);
        check("tie2_mem_we",   64'(mem_we),   64'd0);
        check("tie2_mem_type", 64'(mem_type), 64'd3);
        mem_ack = 1'b1; mem_rdata = 64'hAB;
        step();
        check("tie2_i_done",  64'(i_done), 64'd1);
        check("tie2_i_rdata", i_rdata,     64'hAB);
        check("tie2_d_rdata_hold", d_rdata, 64'h77);
        mem_ack = 1'b0;
        i_addr = 64'h1108; d_req = 1'b1; d_addr = 64'h2008; d_type = 3'd3;
        step();
        step();
        check("tie3_mem_addr", mem_addr,    64'h2008);
        check("tie3_mem_we",   64'(mem_we), 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'h88;
        step();
        check("tie3_d_done", 64'(d_done), 64'd1);
        check("tie3_i_done", 64'(i_done), 64'd0);
        mem_ack = 1'b0; i_req = 1'b0; d_req = 1'b0;
        step();
        step();
        $display("txn tie store=2000 fetch=1100 load=2008 d_rdata=%h", d_rdata);

        // ---- Back-to-back loads ----
        pulses = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h3000;
        step();
        if (d_done) pulses++;
        check("b2b_mem_addr1", mem_addr, 64'h3000);
        mem_ack = 1'b1; mem_rdata = 64'h11;
        step();
        if (d_done) pulses++;
        check("b2b_d_rdata1", d_rdata, 64'h11);
        mem_ack = 1'b0; d_addr = 64'h3008;
        step();
        if (d_done) pulses++;
        check("b2b_gap_req", 64'(mem_req), 64'd0);
        step();
        if (d_done) pulses++;
        check("b2b_mem_req2",  64'(mem_req), 64'd1);
        check("b2b_mem_addr2", mem_addr,     64'h3008);
        mem_ack = 1'b1; mem_rdata = 64'h22;
        step();
        if (d_done) pulses++;
        check("b2b_d_rdata2", d_rdata, 64'h22);
        mem_ack = 1'b0; d_req = 1'b0;
        step();
        if (d_done) pulses++;
        step();
        if (d_done) pulses++;
        check("b2b_done_pulses", 64'(pulses), 64'd2);
        $display("txn b2b loads 3000/3008 pulses=%0d", pulses);

        // ---- Timeout (TIMEOUT=4) ----
        d_req = 1'b1; d_addr = 64'h4000;
        step(); check("to_mem_req_c1", 64'(mem_req), 64'd1);
        step(); check("to_mem_req_c2", 64'(mem_req), 64'd1);
        step(); check("to_mem_req_c3", 64'(mem_req), 64'd1);
        step(); check("to_mem_req_c4", 64'(mem_req), 64'd1);
        check("to_no_done_yet", 64'(d_done), 64'd0);
        step();
        check("to_mem_req_off", 64'(mem_req), 64'd0);
        check("to_d_done",      64'(d_done),  64'd1);
        check("to_bus_err",     64'(bus_err), 64'd1);
        check("to_d_rdata",     d_rdata,      64'd0);
        d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hBAD;
        step();
        check("to_bus_err_clr", 64'(bus_err), 64'd0);
        check("to_d_done_clr",  64'(d_done),  64'd0);
        step();
        check("to_late_ack_req",   64'(mem_req), 64'd0);
        check("to_late_ack_done",  64'(d_done),  64'd0);
        check("to_late_ack_rdata", d_rdata,      64'd0);
        mem_ack = 1'b0;
        $display("txn timeout addr=4000 bus_err seen");

        // ---- Ack on the last allowed BUSY cycle ----
        d_req = 1'b1; d_addr = 64'h5000;
        step(); step(); step(); step();
        check("lim_mem_req_c4", 64'(mem_req), 64'd1);
        mem_ack = 1'b1; mem_rdata = 64'h55;
        step();
        check("lim_d_done",  64'(d_done),  64'd1);
        check("lim_bus_err", 64'(bus_err), 64'd0);
        check("lim_d_rdata", d_rdata,      64'h55);
        mem_ack = 1'b0; d_req = 1'b0;
        step();
        $display("txn ack-at-limit addr=5000 rdata=%h", d_rdata);

        // ---- Reset in the middle of a fetch ----
        i_req = 1'b1; i_addr = 64'h6000;
        step();
        check("mid_mem_req_c1", 64'(mem_req), 64'd1);
        step();
        reset = 1'b1;
        step();
        check("mid_mem_req_rst", 64'(mem_req), 64'd0);
        check("mid_i_done_rst",  64'(i_done),  64'd0);
        reset = 1'b0; i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h99;
        step();
        check("mid_ack_ign_done", 64'(i_done),  64'd0);
        check("mid_ack_ign_req",  64'(mem_req), 64'd0);
        step();
        check("mid_ack_ign_rdata", i_rdata, 64'd0);
        mem_ack = 1'b0;
        $display("txn reset mid-fetch addr=6000 aborted");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
